// File: rtl/div_pkg.sv
// Shared constants and state type for the sequential restoring divider.
package div_pkg;
    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
endpackage

// File: rtl/cpa32.sv
// 32-bit ripple-carry adder; the divider drives it as a subtractor (~y, cin=1).
module cpa32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);
    logic [32:0] carry;

    always_comb begin
        sum      = '0;
        carry    = '0;
        carry[0] = cin;
        for (int i = 0; i < 32; i++) begin
            sum[i]       = x[i] ^ y[i] ^ carry[i];
            carry[i+1]   = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
        end
        cout = carry[32];
    end
endmodule

// File: rtl/div32_seq.sv
// Radix-2 restoring unsigned 32/32 divider: one quotient bit per cycle via a
// trial subtraction through a single cpa32, with a divide-by-zero shortcut.
module div32_seq
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] dvs_work;
    logic [WIDTH-1:0] quo_work;
    logic [WIDTH-1:0] rem_work;
    logic [CNT_W-1:0] cnt;

    logic             accept;
    logic             zero_dvs;
    logic             last_iter;
    logic [WIDTH:0]   partial;
    logic [WIDTH-1:0] diff;
    logic             diff_cout;
    logic             ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;

    assign accept    = start & (state != RUN);
    assign zero_dvs  = (divisor == '0);
    assign last_iter = (cnt == CNT_W'(WIDTH - 1));

    // partial[WIDTH] is the bit shifted out of R; when set, P >= 2^32 > D.
    assign partial = {rem_work, quo_work[WIDTH-1]};

    cpa32 u_sub (
        .x    (partial[WIDTH-1:0]),
        .y    (~dvs_work),
        .cin  (1'b1),
        .sum  (diff),
        .cout (diff_cout)
    );

    assign ge       = partial[WIDTH] | diff_cout;
    assign rem_next = ge ? diff : partial[WIDTH-1:0];
    assign quo_next = {quo_work[WIDTH-2:0], ge};

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = zero_dvs ? DONE : RUN;
            RUN:  if (last_iter) state_next = DONE;
            DONE: begin
                if (accept) state_next = zero_dvs ? DONE : RUN;
                else        state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            dvs_work    <= '0;
            quo_work    <= '0;
            rem_work    <= '0;
            cnt         <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next == RUN);
            done  <= (state_next == DONE);
            if (accept) begin
                dvs_work <= divisor;
                quo_work <= dividend;
                rem_work <= '0;
                cnt      <= '0;
                // Zero divisor completes on the accept edge, so the dividend
                // is captured straight into the remainder output.
                if (zero_dvs) begin
                    quotient    <= DIV0_QUOTIENT;
                    remainder   <= dividend;
                    div_by_zero <= 1'b1;
                end
            end else if (state == RUN) begin
                rem_work <= rem_next;
                quo_work <= quo_next;
                cnt      <= cnt + 1'b1;
                if (last_iter) begin
                    quotient    <= quo_next;
                    remainder   <= rem_next;
                    div_by_zero <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_div32_seq.sv
// Directed and random bench for div32_seq with a cycle-level behavioural model.
module tb_div32_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    div32_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    // Model: cycles left until done, results from plain / and %.
    int          m_left = 0;
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    bit          m_z    = 1'b0;
    logic [31:0] m_q    = '0;
    logic [31:0] m_r    = '0;
    logic [31:0] p_q    = '0;
    logic [31:0] p_r    = '0;

    always @(posedge clk) begin
        bit acc;
        acc = start && (m_left == 0);
        if (reset) begin
            m_left = 0;
            m_done = 1'b0;
            m_q    = '0;
            m_r    = '0;
            m_z    = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) begin
                    m_done = 1'b1;
                    m_q    = p_q;
                    m_r    = p_r;
                    m_z    = 1'b0;
                end
            end else if (acc) begin
                if (divisor == 0) begin
                    m_done = 1'b1;
                    m_q    = 32'hFFFF_FFFF;
                    m_r    = dividend;
                    m_z    = 1'b1;
                end else begin
                    m_left = 32;
                    p_q    = dividend / divisor;
                    p_r    = dividend % divisor;
                end
            end
        end
        m_busy = (m_left > 0);
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
            chk("cyc_done", {31'd0, done}, {31'd0, m_done});
            chk("cyc_quotient", quotient, m_q);
            chk("cyc_remainder", remainder, m_r);
            chk("cyc_div_by_zero", {31'd0, div_by_zero}, {31'd0, m_z});
        end
    end

    // Called at a negedge; returns at the negedge where done is seen (or bound hit).
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        lat      = 0;
        bcnt     = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            lat++;
            if (busy) bcnt++;
        end while (!done && lat < 40);
    endtask

    task automatic chk_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] wq, input logic [31:0] wr, input bit wz,
                          input int wlat);
        int lat;
        int bcnt;
        run_op(a, b, lat, bcnt);
        chk({name, "_lat"}, lat, wlat);
        chk({name, "_q"}, quotient, wq);
        chk({name, "_r"}, remainder, wr);
        chk({name, "_z"}, {31'd0, div_by_zero}, {31'd0, wz});
        if (wlat == 33) chk({name, "_busy_cycles"}, bcnt, 32);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        int lat;
        int bcnt;
        logic [31:0] a;
        logic [31:0] b;
        int sel;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        chk_op("basic", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        @(negedge clk);
        chk_op("max_by_1", 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 33);
        @(negedge clk);
        chk_op("small_by_max", 32'd3, 32'hFFFF_FFFF, 32'd0, 32'd3, 1'b0, 33);
        @(negedge clk);
        chk_op("p33", 32'hFFFF_FFFF, 32'h8000_0001, 32'd1, 32'h7FFF_FFFE, 1'b0, 33);
        @(negedge clk);
        chk_op("div0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5, 1'b1, 1);
        @(negedge clk);
        chk_op("after_div0", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        @(negedge clk);

        // start during RUN must be ignored
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        dividend = 32'd9;
        divisor  = 32'd2;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("midrun_lat", 11 + n, 33);
        chk("midrun_q", quotient, 32'd14);
        chk("midrun_r", remainder, 32'd2);

        // start in the DONE cycle is accepted back-to-back
        @(negedge clk);
        chk_op("b2b_first", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        chk_op("b2b_second", 32'd9, 32'd2, 32'd4, 32'd1, 1'b0, 33);
        chk_op("b2b_div0", 32'd77, 32'd0, 32'hFFFF_FFFF, 32'd77, 1'b1, 1);
        chk_op("b2b_after_div0", 32'd1000, 32'd10, 32'd100, 32'd0, 1'b0, 33);
        @(negedge clk);

        // reset mid-RUN
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_busy", {31'd0, busy}, 0);
        chk("midrst_done", {31'd0, done}, 0);
        chk("midrst_q", quotient, 0);
        chk("midrst_r", remainder, 0);
        chk("midrst_z", {31'd0, div_by_zero}, 0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("midrst_no_done", seen, 0);
        chk_op("after_rst", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 33);
        @(negedge clk);

        // random regression, zero and small divisors mixed in
        for (int i = 0; i < 200; i++) begin
            a   = $urandom;
            sel = $urandom_range(0, 7);
            if (sel == 0)      b = 32'd0;
            else if (sel < 3)  b = $urandom_range(1, 255);
            else if (sel == 3) b = a >> $urandom_range(0, 31);
            else               b = $urandom;
            run_op(a, b, lat, bcnt);
            if (b == 0) begin
                chk("rnd_lat0", lat, 1);
                chk("rnd_q0", quotient, 32'hFFFF_FFFF);
                chk("rnd_r0", remainder, a);
            end else begin
                chk("rnd_lat", lat, 33);
                chk("rnd_q", quotient, a / b);
                chk("rnd_r", remainder, a % b);
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
